// File: rtl/hamming_pkg.sv
// Shared types and sizing helpers for the streaming Hamming-distance block.
package hamming_pkg;

    localparam int unsigned DEF_WIDTH = 256;
    localparam int unsigned DEF_CHUNK = 32;

    typedef enum logic {
        ACCUM,
        DONE
    } state_e;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int unsigned dist_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational population count of an N-bit vector.
module hamming_popcount #(
    parameter int unsigned N = 32,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  data,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/hamming_stream.sv
// Streaming Hamming distance: accumulates popcount(in_a ^ in_b) over BEATS chunk pairs.
// Optional distance threshold compare enabled by HAMMING_STREAM_THRESH_EN.
module hamming_stream
    import hamming_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK,
    localparam int unsigned BEATS = WIDTH / CHUNK,
    localparam int unsigned DIST_W = dist_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHUNK-1:0]  in_a,
    input  logic [CHUNK-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIST_W-1:0] out_dist
`ifdef HAMMING_STREAM_THRESH_EN
    ,
    input  logic [DIST_W-1:0] thresh,
    output logic              out_match
`endif
);

    localparam int unsigned PC_W  = $clog2(CHUNK + 1);
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIST_W-1:0] acc_q, acc_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic [PC_W-1:0]   chunk_pop;
    logic [DIST_W-1:0] sum;
    logic              match_q, match_d;

    hamming_popcount #(
        .N(CHUNK)
    ) u_popcount (
        .data (in_a ^ in_b),
        .count(chunk_pop)
    );

    assign sum = acc_q + DIST_W'(chunk_pop);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dist_d    = dist_q;
        match_d   = match_q;
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);

        if (clear) begin
            // Abort wins over any beat or result handshake in the same cycle.
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            match_d = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = sum;
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            cnt_d   = '0;
                            dist_d  = sum;
`ifdef HAMMING_STREAM_THRESH_EN
                            match_d = (sum <= thresh);
`endif
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_d   = '0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            dist_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dist_q  <= dist_d;
            match_q <= match_d;
        end
    end

    assign out_dist = dist_q;

`ifdef HAMMING_STREAM_THRESH_EN
    assign out_match = match_q;
`else
    logic unused_match;
    assign unused_match = match_q;
`endif

endmodule

// File: tb/tb_hamming_stream.sv
// Directed self-checking bench for hamming_stream at WIDTH=256, CHUNK=32.
module tb_hamming_stream;

    localparam int unsigned DIST_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DIST_W-1:0] out_dist;
`ifdef HAMMING_STREAM_THRESH_EN
    logic [DIST_W-1:0] thresh;
    logic              out_match;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hamming_stream #(
        .WIDTH(256),
        .CHUNK(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dist (out_dist)
`ifdef HAMMING_STREAM_THRESH_EN
        ,
        .thresh   (thresh),
        .out_match(out_match)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else passes++;
        checks++;
        if (out_dist !== 9'd0) $display("FAIL reset_out_dist got %0d want 0", out_dist);
        else passes++;
    endtask

    task automatic test_identical();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(32'hDEADBEEF, 32'hDEADBEEF);
        checks++;
        if (out_valid !== 1'b1) $display("FAIL ident_valid got %b want 1", out_valid);
        else passes++;
        checks++;
        if (out_dist !== 9'd0) $display("FAIL ident_dist got %0d want 0", out_dist);
        else passes++;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL ident_in_ready got %b want 0", in_ready);
        else passes++;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL ident_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_complement();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(32'hFFFFFFFF, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd256)
            $display("FAIL compl_dist got valid=%b dist=%0d want 1/256", out_valid, out_dist);
        else passes++;
`ifdef HAMMING_STREAM_THRESH_EN
        checks++;
        if (out_match !== 1'b0) $display("FAIL compl_match got %b want 0", out_match);
        else passes++;
`endif
        step();
    endtask

    task automatic test_gaps();
        logic [31:0] b;
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            b = (32'h1 << k) - 32'h1;
            send_beat(32'h0, b);
            if (k < 8) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0)
                    $display("FAIL gaps_accum got ready=%b valid=%b want 1/0", in_ready, out_valid);
                else passes++;
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd36 || in_ready !== 1'b0)
            $display("FAIL gaps_dist got valid=%b dist=%0d ready=%b want 1/36/0",
                     out_valid, out_dist, in_ready);
        else passes++;
`ifdef HAMMING_STREAM_THRESH_EN
        checks++;
        if (out_match !== 1'b1) $display("FAIL gaps_match got %b want 1", out_match);
        else passes++;
`endif
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h3, 32'h0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_dist !== 9'd16 || in_ready !== 1'b0)
                $display("FAIL bp_hold got valid=%b dist=%0d ready=%b want 1/16/0",
                         out_valid, out_dist, in_ready);
            else passes++;
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        send_beat(32'hFFFFFFFF, 32'h0);
        for (int i = 1; i < 8; i++) send_beat(32'h5, 32'h5);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd32)
            $display("FAIL bp_second got valid=%b dist=%0d want 1/32", out_valid, out_dist);
        else passes++;
        step();
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(32'hFF, 32'h0);
        clear = 1'b1;
        send_beat(32'hFF, 32'h0);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h1, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd8)
            $display("FAIL clear_accum got valid=%b dist=%0d want 1/8", out_valid, out_dist);
        else passes++;
        step();

        // Clear while a result is pending drops it even with out_ready high.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h3, 32'h0);
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL clear_done got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else passes++;
        for (int i = 0; i < 8; i++) send_beat(32'h7, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd24)
            $display("FAIL clear_next got valid=%b dist=%0d want 1/24", out_valid, out_dist);
        else passes++;
        step();
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(32'hFF, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_dist !== 9'd0)
            $display("FAIL rst_mid got ready=%b valid=%b dist=%0d want 1/0/0",
                     in_ready, out_valid, out_dist);
        else passes++;
        for (int i = 0; i < 8; i++) send_beat(32'h0, 32'h3);
        checks++;
        if (out_valid !== 1'b1 || out_dist !== 9'd16)
            $display("FAIL rst_next got valid=%b dist=%0d want 1/16", out_valid, out_dist);
        else passes++;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef HAMMING_STREAM_THRESH_EN
        thresh    = 9'd36;
`endif
        test_reset();
        test_identical();
        test_complement();
        test_gaps();
        test_backpressure();
        test_clear();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
